// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and parity selection.
// Imported by uart_tx_fifo.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers wrap modulo DEPTH (power of two).
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DWIDTH-1:0]        rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (level == (AW+1)'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && (level != '0);
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; simultaneous push and pop keeps level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            if (do_wr && !do_rd)      level <= level + (AW+1)'(1);
            else if (do_rd && !do_wr) level <= level - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a sync_fifo; frame settings latched per frame.
// Define UART_TX_FIFO_LEVEL_EN to expose the fifo_level output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DWIDTH-1:0]      wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   parity_en,
    input  logic                   parity_type,
    input  logic                   stop2,
    input  logic [PWIDTH-1:0]      prescale,
    output logic                   s_data,
    output logic                   busy,
    output logic                   overflow
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(DWIDTH + 1);

    tx_state_t         state;
    tx_state_t         state_n;
    logic [PWIDTH-1:0] ps_cnt;
    logic [PWIDTH-1:0] ps_r;
    logic [PWIDTH-1:0] ps_eff;
    logic [BW-1:0]     bit_cnt;
    logic [DWIDTH-1:0] shreg;
    logic              par_r;
    logic              par_en_r;
    logic              stop2_r;
    logic [DWIDTH-1:0] fifo_rd_data;
    logic              fifo_full;
    logic [LW-1:0]     level;
    logic              fifo_empty;
    logic              wr_en;
    logic              pop;
    logic              bit_end;

    assign wr_ready   = !fifo_full;
    assign wr_en      = wr_valid && !fifo_full;
    assign fifo_empty = (level == '0);
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    assign ps_eff     = (ps_r == '0) ? PWIDTH'(1) : ps_r;
    assign bit_end    = (state != ST_IDLE) && (ps_cnt == ps_eff - PWIDTH'(1));

`ifdef UART_TX_FIFO_LEVEL_EN
    assign fifo_level = level;
`endif

    sync_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .level   (level)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state; a pop starts every frame, back-to-back from STOP.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_n = ST_START;
                    pop     = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == BW'(DWIDTH - 1))
                    state_n = par_en_r ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_end) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end && (!stop2_r || bit_cnt == BW'(1))) begin
                    if (!fifo_empty) begin
                        state_n = ST_START;
                        pop     = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Bit timing, shifter, latched frame settings and serial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt   <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_r    <= 1'b0;
            par_en_r <= 1'b0;
            stop2_r  <= 1'b0;
            ps_r     <= '0;
            s_data   <= 1'b1;
        end else begin
            if (pop || bit_end || state == ST_IDLE) ps_cnt <= '0;
            else                                    ps_cnt <= ps_cnt + PWIDTH'(1);

            if (state_n != state) bit_cnt <= '0;
            else if (bit_end)     bit_cnt <= bit_cnt + BW'(1);

            if (pop) begin
                shreg    <= fifo_rd_data;
                par_r    <= (^fifo_rd_data) ^ (parity_type == PARITY_ODD);
                par_en_r <= parity_en;
                stop2_r  <= stop2;
                ps_r     <= prescale;
                s_data   <= 1'b0;
            end else if (bit_end) begin
                unique case (state_n)
                    ST_DATA: begin
                        s_data <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                    ST_PARITY: s_data <= par_r;
                    default:   s_data <= 1'b1;
                endcase
            end
        end
    end

    // Sticky flag for writes dropped while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       overflow <= 1'b0;
        else if (wr_valid && fifo_full) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (DEPTH=4) against a queue model
// of the serial line built from whole frames.
module tb_uart_tx_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic [5:0] prescale;
    logic       s_data;
    logic       busy;
    logic       overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [2:0] fifo_level;
`endif

    uart_tx_fifo #(
        .DWIDTH (8),
        .PWIDTH (6),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .prescale    (prescale),
        .s_data      (s_data),
        .busy        (busy),
        .overflow    (overflow)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .fifo_level  (fifo_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int tix    = 0;
    int busy_n = 0;

    logic [7:0] mq[$];
    bit         line_q[$];
    bit         m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (line_q.size() > 0) || (mq.size() > 0);
    endfunction

    // Append the per-clock line levels of one whole frame.
    function automatic void push_frame(input logic [7:0] b);
        int p;
        bit bits[$];
        p = (prescale == 0) ? 1 : int'(prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (parity_en)
            bits.push_back(bit'(($countones(b) % 2) == 1) ^ parity_type);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[k])
            for (int j = 0; j < p; j++) line_q.push_back(bits[k]);
    endfunction

    // Model one clock edge with the inputs present at that edge.
    function automatic void model_edge();
        bit full_pre;
        full_pre = (mq.size() == DEPTH);
        if (line_q.size() > 0) void'(line_q.pop_front());
        if (line_q.size() == 0 && mq.size() > 0) push_frame(mq.pop_front());
        if (wr_valid) begin
            if (!full_pre) mq.push_back(wr_data);
            else           m_ovf = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        tix++;
        if (busy) busy_n++;
        chk("s_data", s_data, (line_q.size() > 0) ? line_q[0] : 1'b1);
        chk("busy", busy, m_busy());
        chk("wr_ready", wr_ready, mq.size() < DEPTH);
        chk("overflow", overflow, m_ovf);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("fifo_level", fifo_level, mq.size());
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && m_busy(); i++) tick();
        if (m_busy()) chk("idle_timeout", 1, 0);
    endtask

    // Write one byte, run to idle, sample the line at a given tick.
    task automatic frame_run(input logic [7:0] b, input int at,
                             output logic v);
        v = 1'bx;
        busy_n = 0;
        tix = -1;
        wr_data = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 3000 && m_busy(); i++) begin
            tick();
            if (tix == at) v = s_data;
        end
        if (m_busy()) chk("frame_timeout", 1, 0);
    endtask

    logic v;

    initial begin
        rst = 1'b1;
        wr_data = '0;
        wr_valid = 1'b0;
        parity_en = 1'b0;
        parity_type = 1'b0;
        stop2 = 1'b0;
        prescale = 6'd4;
        #3;
        chk("rst_s_data", s_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_overflow", overflow, 0);
        tick();
        rst = 1'b0;
        tick();

        // 0xA5, 4 clocks per bit: 40-clock frame, busy for 41 samples.
        frame_run(8'hA5, 6, v);
        chk("a5_bit0", v, 1);
        chk("a5_len", busy_n, 41);

        // Parity of 0x07 at 3 clocks per bit, sampled mid parity bit.
        parity_en = 1'b1;
        prescale = 6'd3;
        parity_type = 1'b0;
        frame_run(8'h07, 29, v);
        chk("par_even", v, 1);
        parity_type = 1'b1;
        frame_run(8'h07, 29, v);
        chk("par_odd", v, 0);
        parity_en = 1'b0;

        // Three back-to-back frames, prescale 2, two stop bits.
        prescale = 6'd2;
        stop2 = 1'b1;
        busy_n = 0;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'($urandom);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        wait_idle();
        chk("three_len", busy_n, 67);
        stop2 = 1'b0;

        // Six writes into DEPTH=4 from idle: fifth fills, sixth drops.
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'($urandom);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        chk("ovf_ready", wr_ready, 0);
        chk("ovf_flag", overflow, 1);
        wait_idle();

        // Prescale 4 -> 8 during a frame; only the next frame slows.
        prescale = 6'd4;
        busy_n = 0;
        wr_data = 8'h3C;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        repeat (10) tick();
        prescale = 6'd8;
        wr_data = 8'hC3;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        wait_idle();
        chk("ps_change_len", busy_n, 121);

        // Asynchronous reset during a data bit with bytes still queued.
        prescale = 6'd4;
        for (int i = 0; i < 2; i++) begin
            wr_data = 8'($urandom);
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_s_data", s_data, 1);
        chk("arst_busy", busy, 0);
        chk("arst_ready", wr_ready, 1);
        chk("arst_ovf", overflow, 0);
        mq.delete();
        line_q.delete();
        m_ovf = 1'b0;
        tick();
        rst = 1'b0;
        repeat (50) tick();

        // Random traffic and per-frame settings, including prescale 0.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = ($urandom_range(0, 5) == 0);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                parity_en = 1'($urandom);
                parity_type = 1'($urandom);
                stop2 = 1'($urandom);
                prescale = 6'($urandom_range(0, 5));
            end
            tick();
        end
        wr_valid = 1'b0;
        wait_idle();
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
